// File: rtl/ysyx_24100005_mem_pkg.sv
// ysyx_24100005_mem_pkg: shared widths, requester ids and arbiter states
package ysyx_24100005_mem_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MASK_W = 8;
  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// ysyx_24100005_rr_arb2: two-way round-robin grant, combinational
module ysyx_24100005_rr_arb2
  import ysyx_24100005_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);
  always_comb begin
    grant_id = &req ? ~last_grant : req[REQ_LSU];
    grant = req & {grant_id, ~grant_id};
  end
endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter: serialises IFU/LSU accesses onto one memory port
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DEF_MASK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              err
);
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d, owner_q, owner_d, wen_q, wen_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [1:0] grant;
  logic grant_id, idle;
  ysyx_24100005_rr_arb2 u_arb (
    .req({lsu_req_valid, ifu_req_valid}),
    .last_grant(last_grant_q),
    .grant(grant),
    .grant_id(grant_id)
  );
  assign idle = state_q == IDLE && !rst;
  assign ifu_req_ready = idle && grant[REQ_IFU];
  assign lsu_req_ready = idle && grant[REQ_LSU];
  assign mem_req_valid = state_q == ISSUE;
  assign mem_req_addr = addr_q;
  assign mem_req_wen = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign ifu_rsp_valid = state_q == RESP && owner_q == REQ_IFU;
  assign lsu_rsp_valid = state_q == RESP && owner_q == REQ_LSU;
  assign ifu_rsp_data = rdata_q;
  assign lsu_rsp_data = rdata_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    owner_d = owner_q;
    addr_d = addr_q;
    wen_d = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d = err_q | (mem_rsp_valid && state_q != WAIT);
    unique case (state_q)
      IDLE: if (idle && |grant) begin
        state_d = ISSUE;
        owner_d = grant_id;
        last_grant_d = grant_id;
        addr_d = grant_id ? lsu_req_addr : ifu_req_addr;
        wen_d = grant_id & lsu_req_wen;
        wdata_d = grant_id ? lsu_req_wdata : '0;
        wmask_d = grant_id ? lsu_req_wmask : '0;
      end
      ISSUE: state_d = mem_req_ready ? WAIT : ISSUE;
      WAIT: if (mem_rsp_valid) begin
        state_d = RESP;
        rdata_d = mem_rsp_data;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_grant_q <= REQ_LSU;
      owner_q <= REQ_IFU;
      addr_q <= '0;
      wen_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wen_q <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// tb_ysyx_24100005_mem_arbiter: directed and random checks against a transaction model
module tb_ysyx_24100005_mem_arbiter;
  logic clk = 0, rst = 1;
  logic ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_req_addr = 0, ifu_rsp_data;
  logic lsu_req_valid = 0, lsu_req_ready, lsu_req_wen = 0, lsu_rsp_valid;
  logic [31:0] lsu_req_addr = 0, lsu_req_wdata = 0, lsu_rsp_data;
  logic [7:0] lsu_req_wmask = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_wen, mem_rsp_valid = 0, err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data = 0;
  logic [7:0] mem_req_wmask;
  ysyx_24100005_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .err(err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  bit tx_on = 0, iss = 0, rsd = 0, own = 0;
  logic [31:0] t_addr = 0, t_wdata = 0, rdata_m = 0;
  logic t_wen = 0, last_m = 1, err_m = 0;
  logic [7:0] t_wmask = 0;
  always @(negedge clk) begin
    logic win, pulse, free, stray;
    if (rst) begin
      tx_on = 0;
      last_m = 1;
      err_m = 0;
      rdata_m = 0;
    end else begin
      free = !tx_on;
      pulse = tx_on && rsd;
      win = (ifu_req_valid && lsu_req_valid) ? !last_m : lsu_req_valid;
      chk("ifu_req_ready", 32'(ifu_req_ready), 32'(free && ifu_req_valid && !win));
      chk("lsu_req_ready", 32'(lsu_req_ready), 32'(free && lsu_req_valid && win));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(tx_on && !iss));
      chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(pulse && !own));
      chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(pulse && own));
      chk("err", 32'(err), 32'(err_m));
      if (tx_on && !iss) begin
        chk("mem_req_addr", mem_req_addr, t_addr);
        chk("mem_req_wen", 32'(mem_req_wen), 32'(t_wen));
        chk("mem_req_wmask", 32'(mem_req_wmask), 32'(t_wmask));
        if (t_wen) chk("mem_req_wdata", mem_req_wdata, t_wdata);
      end
      if (pulse) begin
        chk("ifu_rsp_data", ifu_rsp_data, rdata_m);
        chk("lsu_rsp_data", lsu_rsp_data, rdata_m);
      end
      stray = mem_rsp_valid && !(tx_on && iss && !rsd);
      if (stray) err_m = 1;
      if (pulse) tx_on = 0;
      else if (tx_on && !iss) iss = mem_req_ready;
      else if (tx_on && !rsd && mem_rsp_valid) begin
        rsd = 1;
        rdata_m = mem_rsp_data;
      end
      if (free && (ifu_req_valid || lsu_req_valid)) begin
        tx_on = 1;
        iss = 0;
        rsd = 0;
        own = win;
        last_m = win;
        t_addr = win ? lsu_req_addr : ifu_req_addr;
        t_wen = win && lsu_req_wen;
        t_wdata = lsu_req_wdata;
        t_wmask = win ? lsu_req_wmask : 8'h00;
      end
    end
  end
  logic [31:0] seen_addr, seen_wdata;
  logic seen_wen;
  logic [7:0] seen_wmask;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input bit drop, input int st, input logic [31:0] d, output int lat);
    int c0;
    c0 = cyc;
    tick();
    if (drop) begin
      ifu_req_valid = 0;
      lsu_req_valid = 0;
    end
    mem_req_ready = (st == 0);
    for (int i = 1; i <= st; i++) begin
      tick();
      mem_req_ready = (i == st);
    end
    @(negedge clk);
    seen_addr = mem_req_addr;
    seen_wen = mem_req_wen;
    seen_wdata = mem_req_wdata;
    seen_wmask = mem_req_wmask;
    tick();
    mem_req_ready = 0;
    mem_rsp_valid = 1;
    mem_rsp_data = d;
    tick();
    mem_rsp_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) break;
      tick();
    end
    lat = cyc - c0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    bit ia, la;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_mem_req_wmask", 32'(mem_req_wmask), 32'h0);
    chk("rst_rsp_data", ifu_rsp_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick();
    ifu_req_valid = 1;
    ifu_req_addr = 32'h8000_0000;
    @(negedge clk);
    chk("ifu_read_accept", 32'(ifu_req_ready), 32'h1);
    serve(1, 0, 32'h0000_0413, lat);
    chk("ifu_read_pulse", 32'(ifu_rsp_valid), 32'h1);
    chk("ifu_read_data", ifu_rsp_data, 32'h0000_0413);
    chk("ifu_read_lsu_quiet", 32'(lsu_rsp_valid), 32'h0);
    chk("ifu_read_latency", 32'(lat), 32'd3);
    chk("ifu_read_seen_wen", 32'(seen_wen), 32'h0);
    chk("ifu_read_seen_addr", seen_addr, 32'h8000_0000);
    tick();
    lsu_req_valid = 1;
    lsu_req_addr = 32'h8000_1000;
    lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wmask = 8'h01;
    @(negedge clk);
    chk("lsu_store_accept", 32'(lsu_req_ready), 32'h1);
    serve(1, 0, 32'h0, lat);
    chk("lsu_store_pulse", 32'(lsu_rsp_valid), 32'h1);
    chk("lsu_store_ifu_quiet", 32'(ifu_rsp_valid), 32'h0);
    chk("lsu_store_seen_wen", 32'(seen_wen), 32'h1);
    chk("lsu_store_seen_wmask", 32'(seen_wmask), 32'h1);
    chk("lsu_store_seen_wdata", seen_wdata, 32'hDEAD_BEEF);
    chk("lsu_store_seen_addr", seen_addr, 32'h8000_1000);
    tick();
    ifu_req_valid = 1;
    ifu_req_addr = 32'h8000_0004;
    @(negedge clk);
    serve(1, 5, 32'h1234_5678, lat);
    chk("backpressure_latency", 32'(lat), 32'd8);
    chk("backpressure_data", ifu_rsp_data, 32'h1234_5678);
    tick();
    rst = 1;
    tick();
    rst = 0;
    ifu_req_valid = 1;
    ifu_req_addr = 32'h8000_0100;
    lsu_req_valid = 1;
    lsu_req_wen = 0;
    lsu_req_addr = 32'h8000_2000;
    @(negedge clk);
    chk("contend0_ifu_ready", 32'(ifu_req_ready), 32'h1);
    chk("contend0_lsu_ready", 32'(lsu_req_ready), 32'h0);
    serve(0, 0, 32'hAAAA_0000, lat);
    chk("contend0_ifu_pulse", 32'(ifu_rsp_valid), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      chk("contend_lsu_ready", 32'(lsu_req_ready), 32'(k % 2));
      chk("contend_ifu_ready", 32'(ifu_req_ready), 32'(1 - k % 2));
      serve(k == 3, 0, 32'hAAAA_0000 + 32'(k), lat);
      chk("contend_pulse_owner", 32'(lsu_rsp_valid), 32'(k % 2));
    end
    tick();
    ifu_req_valid = 1;
    ifu_req_addr = 32'h8000_0200;
    tick();
    ifu_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("midreset_no_pulse", 32'(ifu_rsp_valid), 32'h0);
    chk("midreset_idle", 32'(mem_req_valid), 32'h0);
    tick();
    mem_rsp_valid = 1;
    mem_rsp_data = 32'h5555_5555;
    @(negedge clk);
    chk("midreset_err_pending", 32'(err), 32'h0);
    tick();
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("midreset_late_rsp_err", 32'(err), 32'h1);
    chk("midreset_late_rsp_no_pulse", 32'(ifu_rsp_valid), 32'h0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("err_cleared_by_rst", 32'(err), 32'h0);
    tick();
    mem_rsp_valid = 1;
    @(negedge clk);
    chk("stray_no_ifu_pulse", 32'(ifu_rsp_valid), 32'h0);
    chk("stray_no_lsu_pulse", 32'(lsu_rsp_valid), 32'h0);
    tick();
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("stray_err", 32'(err), 32'h1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = ifu_req_valid && ifu_req_ready;
      la = lsu_req_valid && lsu_req_ready;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!ifu_req_valid || ia) begin
        ifu_req_valid = ($urandom_range(0, 2) != 0);
        ifu_req_addr = $urandom;
      end
      if (!lsu_req_valid || la) begin
        lsu_req_valid = ($urandom_range(0, 2) != 0);
        lsu_req_addr = $urandom;
        lsu_req_wen = 1'($urandom_range(0, 1));
        lsu_req_wdata = $urandom;
        lsu_req_wmask = 8'($urandom);
      end
      mem_req_ready = ($urandom_range(0, 2) == 0);
      mem_rsp_valid = (tx_on && iss && !rsd) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      mem_rsp_data = $urandom;
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
